main_memory_read_sequencer: RTL and testbench
=============================================

Name: main_memory_read_sequencer

Overview:
Parametrised successor to the combinational BRAM read mux. It sequences a burst of BRAM word reads from a start address. It then unpacks each wide word into samples and streams them to the USB controller as OUT_WIDTH beats over a valid/ready handshake. Samples wider than OUT_WIDTH are split into two beats, low half first. It sits between the capture BRAM and the USB transmit path.

Parameters:
SAMPLE_WIDTH, 16, bits per ADC sample; legal range 1..2*OUT_WIDTH.
SAMPLES_PER_WORD, 8, samples packed per BRAM word; legal range ≥1.
OUT_WIDTH, 16, output beat width.
ADDR_WIDTH, 10, BRAM address width.
RD_LATENCY, 1, BRAM read latency in cycles (from rd_en to data valid); legal range 1..3.

Ports:
i_clk  in  1  sole clock.
i_rst  in  1  asynchronous, active-high reset.
i_start  in  1  one-cycle burst request; accepted only in IDLE.
i_abort  in  1  synchronous cancel; takes effect in any state.
i_start_addr  in  ADDR_WIDTH  first BRAM word address.
i_word_count  in  ADDR_WIDTH+1  number of BRAM words in the burst.
o_bram_addr  out  ADDR_WIDTH  BRAM read address.
o_bram_rd_en  out  1  BRAM read strobe.
i_bram_data  in  SAMPLE_WIDTH*SAMPLES_PER_WORD  BRAM read data.
o_data  out  OUT_WIDTH  output beat.
o_valid  out  1  o_data is valid.
i_ready  in  1  consumer accepts the beat.
o_last  out  1  final beat of the burst; qualified by o_valid.
o_busy  out  1  high in every state except IDLE.
o_done  out  1  one-cycle pulse on normal burst completion.

Behaviour:
- Reset (async, i_rst=1): state IDLE; all outputs 0; address, counters and capture register cleared.
- Split mode: SPLIT = (SAMPLE_WIDTH > OUT_WIDTH); BEATS = SPLIT ? 2 : 1 per sample.
- Sample k occupies bits [k*SAMPLE_WIDTH +: SAMPLE_WIDTH]. Samples are emitted k=0 upward.
- Non-split beat: sample zero-extended to OUT_WIDTH.
- Split beat 0: sample[OUT_WIDTH-1:0].
- Split beat 1: sample[SAMPLE_WIDTH-1:OUT_WIDTH], zero-extended.
- States:
  - IDLE: on i_start, latch the address and word count. Count 0 -> DONE; otherwise -> ISSUE.
  - ISSUE: o_bram_rd_en=1 for exactly one cycle with o_bram_addr = current address -> WAIT.
  - WAIT: count RD_LATENCY cycles. On the cycle the data is valid, register i_bram_data into the capture register, reset the sample index and half -> SEND.
  - SEND: o_valid=1. o_data is driven from registers only, so it is stable while o_valid=1 and i_ready=0. On o_valid and i_ready, advance the half, then the sample index.
    - After the last beat of a word with words remaining: address+1, wrapping modulo 2^ADDR_WIDTH -> ISSUE.
    - After the last beat of the final word -> DONE.
  - DONE: o_done=1 for one cycle -> IDLE.
- Latency: i_start sampled high in cycle T gives o_bram_rd_en in T+1 and first o_valid in T+2+RD_LATENCY.
- Per-word overhead: 1+RD_LATENCY cycles with o_valid=0. There is no prefetch.
- o_last=1 only on the final beat of the final sample of the final word.
- o_valid falls in the cycle after the handshake of the last beat of each word.
- o_bram_addr holds its last value outside ISSUE. o_bram_rd_en is 0 outside ISSUE.
- i_start while o_busy=1 is ignored, with no effect on the latched parameters.
- i_abort (any state, including concurrent with i_start or a handshake): next state IDLE, o_valid=0 next cycle, no o_done.
  - A beat handshaken in the abort cycle counts as consumed.
  - i_abort has priority over i_start in IDLE.
- i_ready may be held low indefinitely. The block waits in SEND without re-reading BRAM.
- Maximum word count 2^ADDR_WIDTH reads every address exactly once, with wrap.

Test Plan:
1. Defaults; BRAM word k holds samples 16'hk0..16'hk7; start addr 0, count 2, i_ready=1 -> 16 beats 0x0000..0x0007 then 0x0010..0x0017. o_last on beat 16, o_done once. First o_valid at T+3. rd_en at addr 0 and addr 1.
2. SAMPLE_WIDTH=18, SAMPLES_PER_WORD=4, sample0=18'h2ABCD -> beats 0xABCD then 0x0002. 8 beats per word.
3. SAMPLE_WIDTH=12, RD_LATENCY=2, count 1 -> 8 beats zero-extended (upper 4 bits 0). First o_valid at T+4.
4. Random i_ready backpressure, including 20-cycle stalls -> o_data stable while stalled, no lost or duplicated beats, beat order matches the scoreboard.
5. Start addr 2^ADDR_WIDTH-1, count 2 -> reads at addr 1023 then 0. Count 0 -> o_done at T+1 with no beats. i_start while busy is ignored.
6. i_abort mid-SEND (beat 5 of word 1) -> o_valid=0 next cycle, no o_done, o_busy=0. A new i_start then runs cleanly. Async i_rst mid-burst -> all outputs 0 immediately.

Source files
------------

// File: rtl/main_memory_read_sequencer.sv
// Reads a burst of wide BRAM words and streams their samples out as OUT_WIDTH beats over valid/ready.
// First beat 2+RD_LATENCY cycles after start; 1+RD_LATENCY idle cycles per word; holds in SEND while i_ready is low.
module main_memory_read_sequencer #(
    parameter int SAMPLE_WIDTH     = 16,
    parameter int SAMPLES_PER_WORD = 8,
    parameter int OUT_WIDTH        = 16,
    parameter int ADDR_WIDTH       = 10,
    parameter int RD_LATENCY       = 1
) (
    input  logic                                     i_clk,
    input  logic                                     i_rst,
    input  logic                                     i_start,
    input  logic                                     i_abort,
    input  logic [ADDR_WIDTH-1:0]                    i_start_addr,
    input  logic [ADDR_WIDTH:0]                      i_word_count,
    output logic [ADDR_WIDTH-1:0]                    o_bram_addr,
    output logic                                     o_bram_rd_en,
    input  logic [SAMPLE_WIDTH*SAMPLES_PER_WORD-1:0] i_bram_data,
    output logic [OUT_WIDTH-1:0]                     o_data,
    output logic                                     o_valid,
    input  logic                                     i_ready,
    output logic                                     o_last,
    output logic                                     o_busy,
    output logic                                     o_done
);
    localparam int WORD_W = SAMPLE_WIDTH * SAMPLES_PER_WORD;
    localparam int CNT_W  = ADDR_WIDTH + 1;
    localparam int IDX_W  = (SAMPLES_PER_WORD > 1) ? $clog2(SAMPLES_PER_WORD) : 1;
    localparam bit SPLIT  = (SAMPLE_WIDTH > OUT_WIDTH);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(SAMPLES_PER_WORD - 1);
    localparam logic [1:0]       LAST_LAT = 2'(RD_LATENCY - 1);

    typedef enum logic [2:0] {S_IDLE, S_ISSUE, S_WAIT, S_SEND, S_DONE} state_e;

    state_e              state_q, state_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [CNT_W-1:0]    words_q, words_d;
    logic [WORD_W-1:0]   word_q, word_d;
    logic [IDX_W-1:0]    idx_q, idx_d;
    logic                half_q, half_d;
    logic [1:0]          lat_q, lat_d;

    logic [SAMPLE_WIDTH-1:0] samples [SAMPLES_PER_WORD];
    logic [2*OUT_WIDTH-1:0]  sample_ext;
    logic                    last_half;
    logic                    last_word;
    logic                    fire;

    for (genvar k = 0; k < SAMPLES_PER_WORD; k++) begin : g_unpack
        assign samples[k] = word_q[k*SAMPLE_WIDTH +: SAMPLE_WIDTH];
    end

    // Output beat is a pure mux of registered state, so it cannot change while stalled.
    always_comb begin
        sample_ext = '0;
        sample_ext[SAMPLE_WIDTH-1:0] = samples[idx_q];
    end

    assign o_data       = half_q ? sample_ext[2*OUT_WIDTH-1:OUT_WIDTH] : sample_ext[OUT_WIDTH-1:0];
    assign last_half    = SPLIT ? half_q : 1'b1;
    assign last_word    = (words_q == CNT_W'(1));
    assign o_valid      = (state_q == S_SEND);
    assign fire         = o_valid && i_ready;
    assign o_last       = o_valid && last_word && (idx_q == LAST_IDX) && last_half;
    assign o_bram_rd_en = (state_q == S_ISSUE);
    assign o_bram_addr  = addr_q;
    assign o_busy       = (state_q != S_IDLE);
    assign o_done       = (state_q == S_DONE);

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        words_d = words_q;
        word_d  = word_q;
        idx_d   = idx_q;
        half_d  = half_q;
        lat_d   = lat_q;
        case (state_q)
            S_IDLE: begin
                if (i_start) begin
                    addr_d  = i_start_addr;
                    words_d = i_word_count;
                    state_d = (i_word_count == '0) ? S_DONE : S_ISSUE;
                end
            end
            S_ISSUE: begin
                lat_d   = '0;
                state_d = S_WAIT;
            end
            S_WAIT: begin
                if (lat_q == LAST_LAT) begin
                    word_d  = i_bram_data;
                    idx_d   = '0;
                    half_d  = 1'b0;
                    state_d = S_SEND;
                end else begin
                    lat_d = lat_q + 2'd1;
                end
            end
            S_SEND: begin
                if (fire) begin
                    if (!last_half) begin
                        half_d = 1'b1;
                    end else begin
                        half_d = 1'b0;
                        if (idx_q != LAST_IDX) begin
                            idx_d = idx_q + IDX_W'(1);
                        end else if (last_word) begin
                            state_d = S_DONE;
                        end else begin
                            addr_d  = addr_q + ADDR_WIDTH'(1);
                            words_d = words_q - CNT_W'(1);
                            state_d = S_ISSUE;
                        end
                    end
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
        // Abort wins over everything, including a start seen in IDLE.
        if (i_abort) state_d = S_IDLE;
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q <= S_IDLE;
            addr_q  <= '0;
            words_q <= '0;
            word_q  <= '0;
            idx_q   <= '0;
            half_q  <= 1'b0;
            lat_q   <= '0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            words_q <= words_d;
            word_q  <= word_d;
            idx_q   <= idx_d;
            half_q  <= half_d;
            lat_q   <= lat_d;
        end
    end
endmodule

// File: tb/tb_main_memory_read_sequencer.sv
// Bench for main_memory_read_sequencer: a default instance (16-bit samples, latency 1) and a
// split instance (18-bit samples, 4 per word, latency 2, 4-bit address) against a burst-level model.
module tb_main_memory_read_sequencer;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc++;

    int n_tests = 0;
    int n_fail  = 0;

    // Instance A signals
    logic         a_start = 0, a_abort = 0;
    logic [9:0]   a_saddr = '0;
    logic [10:0]  a_cnt = '0;
    logic [9:0]   a_addr;
    logic         a_rd_en;
    logic [127:0] a_bdata;
    logic [15:0]  a_data;
    logic         a_valid, a_last, a_busy, a_done;
    // Instance B signals
    logic         b_start = 0, b_abort = 0;
    logic [3:0]   b_saddr = '0;
    logic [4:0]   b_cnt = '0;
    logic [3:0]   b_addr;
    logic         b_rd_en;
    logic [71:0]  b_bdata;
    logic [15:0]  b_data;
    logic         b_valid, b_last, b_busy, b_done;
    logic         ready = 1'b1;

    main_memory_read_sequencer u_a (
        .i_clk(clk), .i_rst(rst), .i_start(a_start), .i_abort(a_abort),
        .i_start_addr(a_saddr), .i_word_count(a_cnt),
        .o_bram_addr(a_addr), .o_bram_rd_en(a_rd_en), .i_bram_data(a_bdata),
        .o_data(a_data), .o_valid(a_valid), .i_ready(ready), .o_last(a_last),
        .o_busy(a_busy), .o_done(a_done)
    );

    main_memory_read_sequencer #(
        .SAMPLE_WIDTH(18), .SAMPLES_PER_WORD(4), .OUT_WIDTH(16), .ADDR_WIDTH(4), .RD_LATENCY(2)
    ) u_b (
        .i_clk(clk), .i_rst(rst), .i_start(b_start), .i_abort(b_abort),
        .i_start_addr(b_saddr), .i_word_count(b_cnt),
        .o_bram_addr(b_addr), .o_bram_rd_en(b_rd_en), .i_bram_data(b_bdata),
        .o_data(b_data), .o_valid(b_valid), .i_ready(ready), .o_last(b_last),
        .o_busy(b_busy), .o_done(b_done)
    );

    // BRAM models: data is only meaningful on the exact cycle RD_LATENCY after the strobe.
    logic [127:0] mem_a [1024];
    logic [71:0]  mem_b [16];
    logic         a_pv = 1'b0;
    logic [9:0]   a_pa = '0;
    logic [1:0]   b_pv = '0;
    logic [3:0]   b_pa0 = '0, b_pa1 = '0;
    always @(posedge clk) begin
        a_pv  <= a_rd_en;
        a_pa  <= a_addr;
        b_pv  <= {b_pv[0], b_rd_en};
        b_pa0 <= b_addr;
        b_pa1 <= b_pa0;
    end
    assign a_bdata = a_pv    ? mem_a[a_pa]  : '1;
    assign b_bdata = b_pv[1] ? mem_b[b_pa1] : '1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic fail(input string name, input logic [63:0] act);
        n_tests++;
        n_fail++;
        $display("FAIL %s: unexpected event, value %0h (cycle %0d)", name, act, cyc);
    endtask

    // Burst-level reference: expected read addresses and {last, data} beats.
    logic [16:0] exp_beat_a[$], exp_beat_b[$];
    logic [9:0]  exp_addr_a[$];
    logic [3:0]  exp_addr_b[$];
    logic [15:0] b_log[$];

    function automatic void model_a(input int addr, input int count);
        int ad;
        logic [127:0] word;
        for (int w = 0; w < count; w++) begin
            ad   = (addr + w) % 1024;
            word = mem_a[ad];
            exp_addr_a.push_back(10'(ad));
            for (int s = 0; s < 8; s++)
                exp_beat_a.push_back({(w == count-1) && (s == 7), 16'(word >> (s*16))});
        end
    endfunction

    function automatic void model_b(input int addr, input int count);
        int ad;
        logic [71:0] word;
        logic [17:0] smp;
        for (int w = 0; w < count; w++) begin
            ad   = (addr + w) % 16;
            word = mem_b[ad];
            exp_addr_b.push_back(4'(ad));
            for (int s = 0; s < 4; s++) begin
                smp = 18'(word >> (s*18));
                exp_beat_b.push_back({1'b0, smp[15:0]});
                exp_beat_b.push_back({(w == count-1) && (s == 3), 14'd0, smp[17:16]});
            end
        end
    endfunction

    // Monitors sample on the falling edge.
    int beats_a = 0, done_a = 0, fv_a = -1, dc_a = -1, t0_a = 0;
    int beats_b = 0, done_b = 0, fv_b = -1, dc_b = -1, t0_b = 0;
    logic stall_a = 0, stall_b = 0;
    logic [15:0] prev_a = '0, prev_b = '0;

    always @(negedge clk) if (!rst) begin
        if (a_rd_en) begin
            if (exp_addr_a.size() == 0) fail("a_rd_extra", 64'(a_addr));
            else check("a_rd_addr", 64'(a_addr), 64'(exp_addr_a.pop_front()));
        end
        if (a_valid && fv_a < 0) fv_a = cyc;
        if (a_last && !a_valid) fail("a_last_no_valid", 64'(a_data));
        if (a_valid && ready) begin
            beats_a++;
            if (exp_beat_a.size() == 0) fail("a_beat_extra", 64'(a_data));
            else check("a_beat", 64'({a_last, a_data}), 64'(exp_beat_a.pop_front()));
        end
        if (stall_a) check("a_stall_hold", 64'({a_valid, a_data}), 64'({1'b1, prev_a}));
        stall_a = a_valid && !ready && !a_abort;
        prev_a  = a_data;
        if (a_done) begin done_a++; dc_a = cyc; end
    end

    always @(negedge clk) if (!rst) begin
        if (b_rd_en) begin
            if (exp_addr_b.size() == 0) fail("b_rd_extra", 64'(b_addr));
            else check("b_rd_addr", 64'(b_addr), 64'(exp_addr_b.pop_front()));
        end
        if (b_valid && fv_b < 0) fv_b = cyc;
        if (b_valid && ready) begin
            beats_b++;
            b_log.push_back(b_data);
            if (exp_beat_b.size() == 0) fail("b_beat_extra", 64'(b_data));
            else check("b_beat", 64'({b_last, b_data}), 64'(exp_beat_b.pop_front()));
        end
        if (stall_b) check("b_stall_hold", 64'({b_valid, b_data}), 64'({1'b1, prev_b}));
        stall_b = b_valid && !ready && !b_abort;
        prev_b  = b_data;
        if (b_done) begin done_b++; dc_b = cyc; end
    end

    // Consumer: always ready, or random with occasional 20-cycle stalls.
    int rmode = 0;
    int stall_left = 0;
    always @(posedge clk) begin
        #1;
        if (rmode == 0) ready = 1'b1;
        else if (stall_left > 0) begin ready = 1'b0; stall_left--; end
        else if ($urandom_range(0, 15) == 0) begin ready = 1'b0; stall_left = 19; end
        else ready = 1'($urandom_range(0, 1));
    end

    task automatic start_a(input int addr, input int count);
        @(posedge clk); #1;
        a_start = 1'b1; a_saddr = 10'(addr); a_cnt = 11'(count);
        t0_a = cyc; fv_a = -1; dc_a = -1; done_a = 0; beats_a = 0;
        @(posedge clk); #1;
        a_start = 1'b0;
    endtask

    task automatic start_b(input int addr, input int count);
        @(posedge clk); #1;
        b_start = 1'b1; b_saddr = 4'(addr); b_cnt = 5'(count);
        t0_b = cyc; fv_b = -1; dc_b = -1; done_b = 0; beats_b = 0; b_log.delete();
        @(posedge clk); #1;
        b_start = 1'b0;
    endtask

    task automatic wait_done(input bit sel_b, input int budget);
        int n = 0;
        while ((sel_b ? done_b : done_a) == 0 && n < budget) begin @(negedge clk); n++; end
        if ((sel_b ? done_b : done_a) == 0) fail(sel_b ? "b_timeout" : "a_timeout", 64'(n));
        repeat (3) @(posedge clk);
        #1;
    endtask

    task automatic finish_a(input int beats, input int lat, input int dlat);
        check("a_done_count", 64'(done_a), 64'd1);
        check("a_beats", 64'(beats_a), 64'(beats));
        check("a_beats_left", 64'(exp_beat_a.size()), 64'd0);
        check("a_reads_left", 64'(exp_addr_a.size()), 64'd0);
        if (lat >= 0)  check("a_first_valid", 64'(fv_a - t0_a), 64'(lat));
        if (dlat >= 0) check("a_done_time", 64'(dc_a - t0_a), 64'(dlat));
        check("a_idle", 64'(a_busy), 64'd0);
    endtask

    typedef struct { int addr; int count; int beats; int lat; int dlat; } vec_t;
    vec_t vecs[5];

    initial begin : watchdog
        #900000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail + 1);
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        int addr, count;
        vecs[0] = '{addr: 0,    count: 2, beats: 16, lat: 3,  dlat: 21};
        vecs[1] = '{addr: 1023, count: 2, beats: 16, lat: 3,  dlat: 21};
        vecs[2] = '{addr: 5,    count: 0, beats: 0,  lat: -1, dlat: 1};
        vecs[3] = '{addr: 100,  count: 1, beats: 8,  lat: 3,  dlat: 11};
        vecs[4] = '{addr: 1020, count: 5, beats: 40, lat: 3,  dlat: 51};

        for (int k = 0; k < 1024; k++)
            for (int j = 0; j < 8; j++)
                mem_a[k][j*16 +: 16] = 16'((k << 4) | j);
        for (int k = 0; k < 16; k++) mem_b[k] = {8'($urandom), $urandom, $urandom};
        mem_b[0][17:0] = 18'h2ABCD;

        repeat (3) @(posedge clk);
        #1;
        check("a_reset_outputs", 64'({a_rd_en, a_addr, a_data, a_valid, a_last, a_busy, a_done}), 64'd0);
        check("b_reset_outputs", 64'({b_rd_en, b_addr, b_data, b_valid, b_last, b_busy, b_done}), 64'd0);
        rst = 1'b0;

        for (int i = 0; i < 5; i++) begin
            model_a(vecs[i].addr, vecs[i].count);
            start_a(vecs[i].addr, vecs[i].count);
            wait_done(1'b0, 2000);
            finish_a(vecs[i].beats, vecs[i].lat, vecs[i].dlat);
        end

        // Split instance: low half first, then zero-extended high bits; latency 2.
        model_b(0, 1);
        start_b(0, 1);
        wait_done(1'b1, 500);
        check("b_beat0", 64'(b_log.size() > 0 ? b_log[0] : 16'hxxxx), 64'h0000ABCD);
        check("b_beat1", 64'(b_log.size() > 1 ? b_log[1] : 16'hxxxx), 64'h00000002);
        check("b_beats", 64'(beats_b), 64'd8);
        check("b_first_valid", 64'(fv_b - t0_b), 64'd4);
        check("b_done_time", 64'(dc_b - t0_b), 64'd12);
        check("b_done_count", 64'(done_b), 64'd1);

        rmode = 1;
        model_b(14, 3);
        start_b(14, 3);
        wait_done(1'b1, 3000);
        check("b_bp_beats", 64'(beats_b), 64'd24);
        check("b_bp_left", 64'(exp_beat_b.size() + exp_addr_b.size()), 64'd0);
        check("b_bp_done", 64'(done_b), 64'd1);

        for (int k = 0; k < 1024; k++) mem_a[k] = {$urandom, $urandom, $urandom, $urandom};
        for (int i = 0; i < 10; i++) begin
            addr  = $urandom_range(0, 1023);
            count = $urandom_range(0, 4);
            model_a(addr, count);
            start_a(addr, count);
            wait_done(1'b0, 4000);
            finish_a(count * 8, count > 0 ? 3 : -1, -1);
        end
        rmode = 0;
        repeat (25) @(posedge clk);

        // Start pulses while busy must not disturb the running burst.
        model_a(10, 2);
        start_a(10, 2);
        a_start = 1'b1; a_saddr = 10'd500; a_cnt = 11'd3;
        repeat (5) @(posedge clk);
        #1;
        a_start = 1'b0;
        wait_done(1'b0, 500);
        finish_a(16, 3, 21);

        // Abort together with start in IDLE: nothing starts.
        done_a = 0;
        @(posedge clk); #1;
        a_start = 1'b1; a_abort = 1'b1; a_saddr = 10'd33; a_cnt = 11'd1;
        @(posedge clk); #1;
        a_start = 1'b0; a_abort = 1'b0;
        repeat (3) @(negedge clk);
        check("abort_start_busy", 64'(a_busy), 64'd0);
        check("abort_start_done", 64'(done_a), 64'd0);

        // Abort on beat 5 of word 1; that beat is consumed.
        model_a(0, 3);
        start_a(0, 3);
        n = 0;
        while (beats_a < 13 && n < 500) begin @(posedge clk); #1; n++; end
        check("abort_reach_beat", 64'(beats_a), 64'd13);
        a_abort = 1'b1;
        @(posedge clk); #1;
        a_abort = 1'b0;
        @(negedge clk);
        check("abort_valid", 64'(a_valid), 64'd0);
        check("abort_busy", 64'(a_busy), 64'd0);
        repeat (5) @(negedge clk);
        check("abort_done", 64'(done_a), 64'd0);
        check("abort_consumed", 64'(beats_a), 64'd14);
        check("abort_beats_left", 64'(exp_beat_a.size()), 64'd10);
        check("abort_reads_left", 64'(exp_addr_a.size()), 64'd1);
        exp_beat_a.delete();
        exp_addr_a.delete();
        model_a(7, 1);
        start_a(7, 1);
        wait_done(1'b0, 500);
        finish_a(8, 3, 11);

        // Asynchronous reset mid-burst clears outputs without waiting for an edge.
        model_a(0, 2);
        start_a(0, 2);
        n = 0;
        while (!a_valid && n < 50) begin @(posedge clk); #1; n++; end
        #1;
        rst = 1'b1;
        #1;
        check("rst_async_outputs", 64'({a_rd_en, a_addr, a_data, a_valid, a_last, a_busy, a_done}), 64'd0);
        #1;
        rst = 1'b0;
        exp_beat_a.delete();
        exp_addr_a.delete();

        // Full address space with wrap: every address read exactly once.
        model_a(300, 1024);
        start_a(300, 1024);
        wait_done(1'b0, 20000);
        finish_a(8192, 3, 10241);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
